// File: rtl/dma_channel_mmap_if.sv
// MMIO port bundle shared by the DMA loopback register maps.
// Single-cycle reads and no transaction ID.
interface mmio_if;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;

  modport user (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
  modport host (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
endinterface

// File: rtl/dma_channel_mmap.sv
// Multi-channel DMA MMIO register map with per-channel IDLE/BUSY/DONE tracking.
// Optional busy-cycle counter at offset +C when DMA_MMAP_PERF_CNT_EN is defined.
module dma_channel_mmap #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned SIZE_WIDTH   = 17,
  parameter logic [15:0] BASE_ADDR    = 16'h0050,
  parameter logic [15:0] CH_STRIDE    = 16'h0010
) (
  input  logic                                   clk,
  input  logic                                   rst,
  mmio_if.user                                   mmio,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0] size,
  output logic [NUM_CHANNELS-1:0]                 go,
  input  logic [NUM_CHANNELS-1:0]                 done,
  output logic [NUM_CHANNELS-1:0]                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [15:0] ID_ADDR  = 16'(BASE_ADDR + 16'(NUM_CHANNELS) * CH_STRIDE);
  localparam logic [63:0] ID_VALUE = {48'h0, 8'h02, 8'(NUM_CHANNELS)};

  function automatic logic [15:0] ch_base(input int unsigned c);
    return 16'(BASE_ADDR + 16'(c) * CH_STRIDE);
  endfunction

  state_t state_q [NUM_CHANNELS];
  state_t state_d [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] done_q, done_edge, go_req, clr_req, go_d, cfg_we;
  logic [NUM_CHANNELS-1:0] sticky_q, sticky_d, overrun_q, overrun_d;
  logic [63:0]             rd_mux;

`ifdef DMA_MMAP_PERF_CNT_EN
  logic [63:0] perf_q [NUM_CHANNELS];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) state_q[c] <= S_IDLE;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) state_q[c] <= state_d[c];
    end
  end

  always_comb begin
    go_req    = '0;
    clr_req   = '0;
    done_edge = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      go_req[c]    = mmio.wr_en && (mmio.wr_addr == ch_base(c)) && mmio.wr_data[0];
      clr_req[c]   = mmio.wr_en && (mmio.wr_addr == ch_base(c) + 16'hA) && mmio.wr_data[0];
      done_edge[c] = done[c] & ~done_q[c];
      state_d[c]   = state_q[c];
      unique case (state_q[c])
        S_IDLE:  if (go_req[c]) state_d[c] = S_BUSY;
        S_BUSY:  if (done_edge[c]) state_d[c] = S_DONE;
        S_DONE: begin
          if (go_req[c])       state_d[c] = S_BUSY;
          else if (clr_req[c]) state_d[c] = S_IDLE;
        end
        default: state_d[c] = S_IDLE;
      endcase
    end
  end

  // A done edge while BUSY takes priority over a same-cycle clear or go request.
  always_comb begin
    go_d      = '0;
    busy      = '0;
    cfg_we    = '0;
    sticky_d  = sticky_q;
    overrun_d = overrun_q;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      busy[c]   = (state_q[c] == S_BUSY);
      go_d[c]   = go_req[c] && (state_q[c] != S_BUSY);
      cfg_we[c] = mmio.wr_en && (state_q[c] != S_BUSY);
      if (clr_req[c]) begin
        sticky_d[c]  = 1'b0;
        overrun_d[c] = 1'b0;
      end
      if (go_d[c]) sticky_d[c] = 1'b0;
      if (busy[c] && go_req[c])    overrun_d[c] = 1'b1;
      if (busy[c] && done_edge[c]) sticky_d[c]  = 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (mmio.rd_addr == ID_ADDR) rd_mux = ID_VALUE;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (mmio.rd_addr == ch_base(c) + 16'h2) rd_mux = 64'(rd_addr[c]);
      if (mmio.rd_addr == ch_base(c) + 16'h4) rd_mux = 64'(wr_addr[c]);
      if (mmio.rd_addr == ch_base(c) + 16'h6) rd_mux = 64'(size[c]);
      if (mmio.rd_addr == ch_base(c) + 16'h8)
        rd_mux = {61'h0, overrun_q[c], busy[c], sticky_q[c]};
`ifdef DMA_MMAP_PERF_CNT_EN
      if (mmio.rd_addr == ch_base(c) + 16'hC) rd_mux = perf_q[c];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q       <= '0;
      go           <= '0;
      sticky_q     <= '0;
      overrun_q    <= '0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      size         <= '0;
      mmio.rd_data <= '0;
    end else begin
      done_q    <= done;
      go        <= go_d;
      sticky_q  <= sticky_d;
      overrun_q <= overrun_d;
      if (mmio.rd_en) mmio.rd_data <= rd_mux;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (cfg_we[c] && mmio.wr_addr == ch_base(c) + 16'h2)
          rd_addr[c] <= mmio.wr_data[ADDR_WIDTH-1:0];
        if (cfg_we[c] && mmio.wr_addr == ch_base(c) + 16'h4)
          wr_addr[c] <= mmio.wr_data[ADDR_WIDTH-1:0];
        if (cfg_we[c] && mmio.wr_addr == ch_base(c) + 16'h6)
          size[c] <= mmio.wr_data[SIZE_WIDTH-1:0];
      end
    end
  end

`ifdef DMA_MMAP_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) perf_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (go_d[c])                            perf_q[c] <= '0;
        else if (busy[c] && (perf_q[c] != '1))  perf_q[c] <= perf_q[c] + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dma_channel_mmap.sv
// Bench for dma_channel_mmap: directed scenarios plus randomized traffic
// compared against a transaction-level model of the register map.
module tb_dma_channel_mmap;
  localparam int NCH = 4;
  localparam int SW  = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_if m ();
  logic [NCH-1:0][63:0]   rd_addr, wr_addr;
  logic [NCH-1:0][SW-1:0] size;
  logic [NCH-1:0]         go, done, busy;

  dma_channel_mmap #(
    .NUM_CHANNELS(4), .ADDR_WIDTH(64), .SIZE_WIDTH(17),
    .BASE_ADDR(16'h0050), .CH_STRIDE(16'h0010)
  ) dut (
    .clk(clk), .rst(rst), .mmio(m),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .size(size),
    .go(go), .done(done), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Model: a channel is either running a transfer or not; status bits kept as flags.
  bit             mrun [NCH];
  bit             mstk [NCH];
  bit             movr [NCH];
  bit             mprev[NCH];
  logic [63:0]    mra  [NCH];
  logic [63:0]    mwa  [NCH];
  logic [63:0]    mperf[NCH];
  logic [SW-1:0]  msz  [NCH];
  logic [NCH-1:0] mgo;
  logic [63:0]    mrd;
  logic [15:0]    offs [9] = '{16'h0, 16'h2, 16'h4, 16'h6, 16'h8, 16'hA, 16'hC, 16'hE, 16'h1};

  function automatic logic [15:0] base_of(input int c);
    return 16'h0050 + 16'(c) * 16'h0010;
  endfunction

  function automatic logic [63:0] m_read(input logic [15:0] a);
    if (a == 16'h0090) return 64'h0204;
    for (int c = 0; c < NCH; c++) begin
      if (a == base_of(c) + 16'h2) return mra[c];
      if (a == base_of(c) + 16'h4) return mwa[c];
      if (a == base_of(c) + 16'h6) return 64'(msz[c]);
      if (a == base_of(c) + 16'h8) return 64'(mstk[c]) + 64'(movr[c]) * 4 + 64'(mrun[c]) * 2;
`ifdef DMA_MMAP_PERF_CNT_EN
      if (a == base_of(c) + 16'hC) return mperf[c];
`endif
    end
    return 64'h0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mrun[c] = 0; mstk[c] = 0; movr[c] = 0; mprev[c] = 0;
      mra[c] = '0; mwa[c] = '0; msz[c] = '0; mperf[c] = '0;
    end
    mgo = '0;
    mrd = '0;
  endtask

  task automatic model_step();
    logic [63:0] rv;
    bit was_run, rise, gor, clr;
    rv = m_read(m.rd_addr);
    for (int c = 0; c < NCH; c++) begin
      was_run = mrun[c];
      rise = done[c] && !mprev[c];
      gor  = m.wr_en && m.wr_addr == base_of(c) && m.wr_data[0];
      clr  = m.wr_en && m.wr_addr == base_of(c) + 16'hA && m.wr_data[0];
      mgo[c] = 1'b0;
      if (was_run) begin
        if (gor) movr[c] = 1;
        if (clr) movr[c] = 0;
        if (rise) begin mrun[c] = 0; mstk[c] = 1; end
      end else if (gor) begin
        mrun[c] = 1; mstk[c] = 0; mgo[c] = 1'b1;
      end else if (clr) begin
        mstk[c] = 0; movr[c] = 0;
      end
      if (!was_run && m.wr_en) begin
        if (m.wr_addr == base_of(c) + 16'h2) mra[c] = m.wr_data;
        if (m.wr_addr == base_of(c) + 16'h4) mwa[c] = m.wr_data;
        if (m.wr_addr == base_of(c) + 16'h6) msz[c] = m.wr_data[SW-1:0];
      end
      if (mgo[c]) mperf[c] = '0;
      else if (was_run && mperf[c] != 64'hFFFF_FFFF_FFFF_FFFF) mperf[c] = mperf[c] + 1;
      mprev[c] = done[c];
    end
    if (m.rd_en) mrd = rv;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    m.wr_en = 1'b1; m.wr_addr = a; m.wr_data = d;
    tick();
    m.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    m.rd_en = 1'b1; m.rd_addr = a;
    tick();
    m.rd_en = 1'b0;
    d = m.rd_data;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== '0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (go !== '0) begin failures++; $display("FAIL reset_go got=%b exp=0", go); end
    checks++; if (m.rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", m.rd_data); end
    checks++; if (size !== '0 || rd_addr !== '0 || wr_addr !== '0) begin
      failures++; $display("FAIL reset_regs size=%h rd_addr=%h wr_addr=%h exp=0", size, rd_addr, wr_addr);
    end
    model_reset();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ch0_start();
    logic [63:0] d;
    wr(16'h52, 64'h1000); wr(16'h54, 64'h2000); wr(16'h56, 64'd8);
    checks++; if (rd_addr[0] !== 64'h1000 || wr_addr[0] !== 64'h2000 || size[0] !== 17'd8) begin
      failures++; $display("FAIL ch0_cfg got=%h/%h/%h exp=1000/2000/8", rd_addr[0], wr_addr[0], size[0]);
    end
    wr(16'h50, 64'h1);
    checks++; if (go !== 4'b0001) begin failures++; $display("FAIL ch0_go_pulse got=%b exp=0001", go); end
    checks++; if (busy !== 4'b0001) begin failures++; $display("FAIL ch0_busy got=%b exp=0001", busy); end
    tick();
    checks++; if (go !== 4'b0000 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL ch0_go_width go=%b busy0=%b exp go=0000 busy0=1", go, busy[0]);
    end
    rd(16'h52, d);
    checks++; if (d !== 64'h1000) begin failures++; $display("FAIL ch0_read_rdaddr got=%h exp=1000", d); end
  endtask

  task automatic test_ch0_complete();
    logic [63:0] d, exp_perf;
    repeat (2) tick();
    done[0] = 1'b1;
    tick();
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL ch0_done_busy got=%b exp=0", busy[0]); end
    rd(16'h58, d);
    checks++; if (d !== 64'h1) begin failures++; $display("FAIL ch0_status_done got=%h exp=1", d); end
    exp_perf = m_read(16'h5C);
    rd(16'h5C, d);
    checks++; if (d !== exp_perf) begin failures++; $display("FAIL ch0_perf got=%h exp=%h", d, exp_perf); end
    wr(16'h5A, 64'h1);
    rd(16'h58, d);
    checks++; if (d !== 64'h0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL ch0_clear status=%h busy0=%b exp=0/0", d, busy[0]);
    end
  endtask

  task automatic test_overrun();
    logic [63:0] d;
    wr(16'h76, 64'd5);
    wr(16'h70, 64'h1);
    checks++; if (go[2] !== 1'b1) begin failures++; $display("FAIL ch2_first_go got=%b exp=1", go[2]); end
    tick();
    wr(16'h70, 64'h1);
    checks++; if (go[2] !== 1'b0 || busy[2] !== 1'b1) begin
      failures++; $display("FAIL ch2_overrun_go go2=%b busy2=%b exp=0/1", go[2], busy[2]);
    end
    rd(16'h78, d);
    checks++; if (d !== 64'h6) begin failures++; $display("FAIL ch2_status_overrun got=%h exp=6", d); end
    wr(16'h76, 64'd3);
    rd(16'h76, d);
    checks++; if (size[2] !== 17'd5 || d !== 64'd5) begin
      failures++; $display("FAIL ch2_size_locked out=%0d read=%0d exp=5", size[2], d);
    end
    done[2] = 1'b1; tick(); done[2] = 1'b0;
    wr(16'h7A, 64'h1);
    rd(16'h78, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL ch2_clear got=%h exp=0", d); end
  endtask

  task automatic test_isolation_id();
    logic [63:0] d;
    m.wr_en = 1'b1; m.wr_data = 64'h1;
    m.wr_addr = 16'h60; tick();
    m.wr_addr = 16'h80; tick();
    m.wr_en = 1'b0;
    checks++; if (busy !== 4'b1010) begin failures++; $display("FAIL iso_busy got=%b exp=1010", busy); end
    done[3] = 1'b1; tick();
    rd(16'h88, d);
    checks++; if (d !== 64'h1) begin failures++; $display("FAIL iso_ch3_status got=%h exp=1", d); end
    rd(16'h68, d);
    checks++; if (d !== 64'h2) begin failures++; $display("FAIL iso_ch1_status got=%h exp=2", d); end
    rd(16'h90, d);
    checks++; if (d !== 64'h0204) begin failures++; $display("FAIL id_reg got=%h exp=0204", d); end
    rd(16'h4E, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
    done[1] = 1'b1; tick();
    done[1] = 1'b0; done[3] = 1'b0;
    wr(16'h6A, 64'h1); wr(16'h8A, 64'h1);
  endtask

  task automatic test_stale_done();
    logic [63:0] d;
    wr(16'h50, 64'h1);
    checks++; if (go[0] !== 1'b1) begin failures++; $display("FAIL stale_go got=%b exp=1", go[0]); end
    repeat (3) tick();
    checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL stale_held_busy got=%b exp=1", busy[0]); end
    done[0] = 1'b0; tick();
    checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL stale_drop_busy got=%b exp=1", busy[0]); end
    done[0] = 1'b1; tick();
    rd(16'h58, d);
    checks++; if (busy[0] !== 1'b0 || d !== 64'h1) begin
      failures++; $display("FAIL stale_rise busy0=%b status=%h exp=0/1", busy[0], d);
    end
  endtask

  task automatic test_same_cycle();
    logic [63:0] d;
    done[0] = 1'b0;
    wr(16'h50, 64'h1);
    rd(16'h58, d);
    checks++; if (d !== 64'h2) begin failures++; $display("FAIL restart_status got=%h exp=2", d); end
    done[0] = 1'b1;
    wr(16'h5A, 64'h1);
    rd(16'h58, d);
    checks++; if (d !== 64'h1 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL clear_vs_done status=%h busy0=%b exp=1/0", d, busy[0]);
    end
    done[0] = 1'b0;
    wr(16'h50, 64'h1);
    done[0] = 1'b1;
    wr(16'h50, 64'h1);
    checks++; if (go[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL go_vs_done go0=%b busy0=%b exp=0/0", go[0], busy[0]);
    end
    rd(16'h58, d);
    checks++; if (d !== 64'h5) begin failures++; $display("FAIL go_vs_done_status got=%h exp=5", d); end
    wr(16'h5A, 64'h1);
    done[0] = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    wr(16'h50, 64'h1);
    rd(16'h52, d);
    rst = 1'b1;
    #1;
    checks++; if (busy !== '0 || go !== '0) begin
      failures++; $display("FAIL midreset_async busy=%b go=%b exp=0/0", busy, go);
    end
    checks++; if (m.rd_data !== 64'h0) begin failures++; $display("FAIL midreset_rd_data got=%h exp=0", m.rd_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    tick(); tick();
    checks++; if (go !== '0 || busy !== '0) begin
      failures++; $display("FAIL midreset_no_reissue go=%b busy=%b exp=0/0", go, busy);
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0]         eg, eb;
    logic [NCH-1:0][63:0]   era, ewa;
    logic [NCH-1:0][SW-1:0] esz;
    for (int i = 0; i < 400; i++) begin
      m.wr_en   = 1'($urandom_range(0, 1));
      m.wr_addr = ($urandom_range(0, 15) == 0) ? 16'($urandom)
                  : base_of($urandom_range(0, NCH - 1)) + offs[$urandom_range(0, 8)];
      m.wr_data = {$urandom, $urandom};
      m.rd_en   = 1'($urandom_range(0, 1));
      m.rd_addr = ($urandom_range(0, 9) == 0) ? 16'h0090
                  : base_of($urandom_range(0, NCH - 1)) + offs[$urandom_range(0, 8)];
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 3) == 0) done[c] = ~done[c];
      tick();
      for (int c = 0; c < NCH; c++) begin
        eg[c] = mgo[c]; eb[c] = mrun[c];
        era[c] = mra[c]; ewa[c] = mwa[c]; esz[c] = msz[c];
      end
      checks++; if (go !== eg) begin failures++; $display("FAIL rand_go it=%0d got=%b exp=%b", i, go, eg); end
      checks++; if (busy !== eb) begin failures++; $display("FAIL rand_busy it=%0d got=%b exp=%b", i, busy, eb); end
      checks++; if (m.rd_data !== mrd) begin failures++; $display("FAIL rand_rd_data it=%0d got=%h exp=%h", i, m.rd_data, mrd); end
      checks++; if (rd_addr !== era) begin failures++; $display("FAIL rand_rd_addr it=%0d got=%h exp=%h", i, rd_addr, era); end
      checks++; if (wr_addr !== ewa) begin failures++; $display("FAIL rand_wr_addr it=%0d got=%h exp=%h", i, wr_addr, ewa); end
      checks++; if (size !== esz) begin failures++; $display("FAIL rand_size it=%0d got=%h exp=%h", i, size, esz); end
    end
    m.wr_en = 1'b0;
    m.rd_en = 1'b0;
  endtask

  initial begin
    m.wr_en = 1'b0; m.wr_addr = '0; m.wr_data = '0;
    m.rd_en = 1'b0; m.rd_addr = '0;
    done = '0;
    test_reset();
    test_ch0_start();
    test_ch0_complete();
    test_overrun();
    test_isolation_id();
    test_stale_done();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
